sift_desc_packer: RTL and testbench

SIFT_DESC_PACKER -- requirements
Module: sift_desc_packer

---
 rtl/sift_desc_packer.sv | 115 +++++++++++
 tb/tb_sift_desc_packer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/sift_desc_packer.sv
// Packs a byte stream of SIFT descriptors into little-endian 32-bit words and
// buffers them in a FIFO, dropping whole descriptors when the FIFO overflows.
module sift_desc_packer #(
  parameter int DESC_BYTES = 128,
  parameter int FIFO_AW    = 6
) (
  input  logic        clk_sys,
  input  logic        rst_sys,
  input  logic        desc_valid,
  input  logic [7:0]  desc_byte,
  input  logic        frame_done,
  output logic [31:0] m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        m_last,
  output logic [15:0] desc_count,
  output logic        overflow,
  output logic        frame_err
);

  localparam int BW    = $clog2(DESC_BYTES);
  localparam int DEPTH = 1 << FIFO_AW;

  typedef enum logic [1:0] {IDLE, COLLECT, DROP} state_t;

  state_t             state;
  logic [BW-1:0]      byte_cnt;
  logic [BW-1:0]      byte_cnt_nxt;
  logic [23:0]        word_buf;
  logic [32:0]        mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   fifo_cnt;
  logic               word_done;
  logic               last_byte;
  logic               fifo_full;
  logic               rd_en;
  logic               wr_en;
  logic               drop_word;

  assign m_valid = (fifo_cnt != '0);
  assign m_data  = m_valid ? mem[rd_ptr][31:0] : '0;
  assign m_last  = m_valid ? mem[rd_ptr][32] : 1'b0;

  // A full FIFO still takes a word if the consumer frees a slot on the same edge.
  always_comb begin
    rd_en     = m_valid && m_ready;
    fifo_full = (fifo_cnt == (FIFO_AW+1)'(DEPTH));
    word_done = desc_valid && (byte_cnt[1:0] == 2'd3);
    last_byte = desc_valid && (byte_cnt == BW'(DESC_BYTES - 1));
    wr_en     = word_done && (state != DROP) && (!fifo_full || rd_en);
    drop_word = word_done && (state != DROP) && fifo_full && !rd_en;
    byte_cnt_nxt = byte_cnt;
    if (last_byte)
      byte_cnt_nxt = '0;
    else if (desc_valid)
      byte_cnt_nxt = byte_cnt + BW'(1);
  end

  always_ff @(posedge clk_sys or posedge rst_sys) begin
    if (rst_sys) begin
      state      <= IDLE;
      byte_cnt   <= '0;
      word_buf   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_cnt   <= '0;
      desc_count <= '0;
      overflow   <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_cnt <= frame_done ? '0 : byte_cnt_nxt;
      if (frame_done && (byte_cnt_nxt != '0))
        frame_err <= 1'b1;

      if (desc_valid) begin
        case (byte_cnt[1:0])
          2'd0:    word_buf[7:0]   <= desc_byte;
          2'd1:    word_buf[15:8]  <= desc_byte;
          2'd2:    word_buf[23:16] <= desc_byte;
          default: word_buf        <= word_buf;
        endcase
      end

      if (drop_word)
        overflow <= 1'b1;
      if (wr_en && last_byte && (desc_count != 16'hFFFF))
        desc_count <= desc_count + 16'd1;

      // Once a word is lost the rest of that descriptor is swallowed.
      if (frame_done || last_byte)
        state <= IDLE;
      else if (drop_word)
        state <= DROP;
      else if (desc_valid && (state == IDLE))
        state <= COLLECT;

      if (wr_en)
        wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (rd_en)
        rd_ptr <= rd_ptr + FIFO_AW'(1);
      case ({wr_en, rd_en})
        2'b10:   fifo_cnt <= fifo_cnt + (FIFO_AW+1)'(1);
        2'b01:   fifo_cnt <= fifo_cnt - (FIFO_AW+1)'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (wr_en)
      mem[wr_ptr] <= {last_byte, desc_byte, word_buf};
  end

endmodule

// File: tb/tb_sift_desc_packer.sv
// Scoreboard bench for sift_desc_packer: stimulus pushes expected words,
// a negedge monitor pops and compares every accepted output word.
module tb_sift_desc_packer;

  localparam int DB = 128;

  logic        clk_sys = 1'b0;
  logic        rst_sys = 1'b0;
  logic        desc_valid = 1'b0;
  logic [7:0]  desc_byte = 8'h00;
  logic        frame_done = 1'b0;
  logic        m_ready = 1'b0;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_last;
  logic [15:0] desc_count;
  logic        overflow;
  logic        frame_err;

  logic [32:0] exp_q[$];
  logic [32:0] mon_exp;
  logic [31:0] acc = '0;
  int          n_checks = 0;
  int          n_fail = 0;

  sift_desc_packer #(.DESC_BYTES(DB), .FIFO_AW(6)) dut (
    .clk_sys    (clk_sys),
    .rst_sys    (rst_sys),
    .desc_valid (desc_valid),
    .desc_byte  (desc_byte),
    .frame_done (frame_done),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_last     (m_last),
    .desc_count (desc_count),
    .overflow   (overflow),
    .frame_err  (frame_err)
  );

  always #5 clk_sys = ~clk_sys;

  function automatic logic [7:0] bval(input int d, input int i);
    return 8'(d * 53 + i);
  endfunction

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Word k of a descriptor is bytes 4k..4k+3, little-endian, last flag on byte DB-1.
  task automatic apply_byte(input int d, input int i, input bit store, input bit fd);
    desc_valid = 1'b1;
    desc_byte  = bval(d, i);
    frame_done = fd;
    acc[8*(i%4) +: 8] = bval(d, i);
    if ((i % 4 == 3) && store)
      exp_q.push_back({(i == DB - 1), acc});
    @(posedge clk_sys);
    #1;
    desc_valid = 1'b0;
    frame_done = 1'b0;
  endtask

  task automatic apply_range(input int d, input int first, input int last, input bit store);
    for (int i = first; i <= last; i++)
      apply_byte(d, i, store, 1'b0);
  endtask

  task automatic apply_reset();
    rst_sys = 1'b1;
    m_ready = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk_sys);
    #1;
    rst_sys = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int k;
    k = 0;
    m_ready = 1'b1;
    while (exp_q.size() != 0 && k < 3000) begin
      @(posedge clk_sys);
      k++;
    end
    repeat (3) @(posedge clk_sys);
    #1;
    check_output({name, "_pending"}, 64'(exp_q.size()), 64'd0);
    check_output({name, "_idle_valid"}, m_valid, 1'b0);
  endtask

  always @(negedge clk_sys) begin
    if (!rst_sys && m_valid === 1'b1 && m_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL unexpected_word: got 0x%0h last=%0b, expected no word", m_data, m_last);
      end else begin
        mon_exp = exp_q.pop_front();
        check_output("word", {m_last, m_data}, mon_exp);
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    #2;
    rst_sys = 1'b1;
    #1;
    check_output("rst_m_valid", m_valid, 1'b0);
    check_output("rst_m_data", m_data, 32'h0);
    check_output("rst_m_last", m_last, 1'b0);
    check_output("rst_desc_count", desc_count, 16'd0);
    check_output("rst_overflow", overflow, 1'b0);
    check_output("rst_frame_err", frame_err, 1'b0);
    apply_reset();

    // Single descriptor 0x00..0x7F streamed straight through.
    m_ready = 1'b1;
    apply_range(0, 0, DB - 1, 1'b1);
    wait_drain("t1");
    check_output("t1_desc_count", desc_count, 16'd1);
    check_output("t1_overflow", overflow, 1'b0);
    check_output("t1_frame_err", frame_err, 1'b0);

    // Stalled consumer: two descriptors fill the FIFO, the third is dropped.
    apply_reset();
    apply_range(1, 0, 2, 1'b1);
    check_output("t2_latency_pre", m_valid, 1'b0);
    apply_byte(1, 3, 1'b1, 1'b0);
    check_output("t2_latency_post", m_valid, 1'b1);
    check_output("t2_first_word", {m_last, m_data}, {1'b0, bval(1, 3), bval(1, 2), bval(1, 1), bval(1, 0)});
    apply_range(1, 4, DB - 1, 1'b1);
    apply_range(2, 0, DB - 1, 1'b1);
    apply_range(3, 0, DB - 1, 1'b0);
    check_output("t2_overflow", overflow, 1'b1);
    check_output("t2_desc_count", desc_count, 16'd2);
    repeat (5) @(posedge clk_sys);
    #1;
    check_output("t2_stall_hold", {m_last, m_data}, {1'b0, bval(1, 3), bval(1, 2), bval(1, 1), bval(1, 0)});
    wait_drain("t2");
    check_output("t2_overflow_sticky", overflow, 1'b1);

    // Full FIFO, but the completing word coincides with a read.
    apply_reset();
    apply_range(4, 0, DB - 1, 1'b1);
    apply_range(5, 0, DB - 1, 1'b1);
    apply_range(6, 0, 2, 1'b1);
    m_ready = 1'b1;
    apply_byte(6, 3, 1'b1, 1'b0);
    apply_range(6, 4, DB - 1, 1'b1);
    wait_drain("t3");
    check_output("t3_overflow", overflow, 1'b0);
    check_output("t3_desc_count", desc_count, 16'd3);

    // frame_done after 50 bytes leaves 12 words and flags the frame.
    apply_reset();
    apply_range(7, 0, 49, 1'b1);
    frame_done = 1'b1;
    @(posedge clk_sys);
    #1;
    frame_done = 1'b0;
    check_output("t4_frame_err", frame_err, 1'b1);
    check_output("t4_desc_count", desc_count, 16'd0);
    check_output("t4_overflow", overflow, 1'b0);
    wait_drain("t4_partial");
    apply_range(8, 0, DB - 1, 1'b1);
    wait_drain("t4_next");
    check_output("t4_next_desc_count", desc_count, 16'd1);
    check_output("t4_frame_err_sticky", frame_err, 1'b1);

    // frame_done on byte 127 completes cleanly; on byte 49 it does not.
    apply_reset();
    m_ready = 1'b1;
    apply_range(9, 0, DB - 2, 1'b1);
    apply_byte(9, DB - 1, 1'b1, 1'b1);
    wait_drain("t5");
    check_output("t5_desc_count", desc_count, 16'd1);
    check_output("t5_frame_err", frame_err, 1'b0);
    apply_range(10, 0, 48, 1'b1);
    apply_byte(10, 49, 1'b1, 1'b1);
    wait_drain("t5_mid");
    check_output("t5_mid_frame_err", frame_err, 1'b1);
    check_output("t5_mid_desc_count", desc_count, 16'd1);

    // Reset in the middle of a descriptor, then a clean one.
    apply_reset();
    apply_range(11, 0, 70, 1'b1);
    check_output("t6_pre_valid", m_valid, 1'b1);
    rst_sys = 1'b1;
    exp_q.delete();
    #1;
    check_output("t6_rst_valid", m_valid, 1'b0);
    check_output("t6_rst_data", m_data, 32'h0);
    check_output("t6_rst_desc_count", desc_count, 16'd0);
    @(posedge clk_sys);
    #1;
    rst_sys = 1'b0;
    m_ready = 1'b1;
    apply_range(12, 0, DB - 1, 1'b1);
    wait_drain("t6");
    check_output("t6_desc_count", desc_count, 16'd1);
    check_output("t6_overflow", overflow, 1'b0);
    check_output("t6_frame_err", frame_err, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
